// File: rtl/load_updown_counter.sv
// Parameterized up/down binary counter with synchronous parallel load and count enable.
// Latency: load/count visible on data_out one edge after the controls are sampled.
// Backpressure: none; every input is sampled on every rising edge.
module load_updown_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    // Load outranks counting; with neither, the value holds.
    always_comb begin
        w_count_nxt = r_count;
        if (load) begin
            w_count_nxt = data_in;
        end else if (enable) begin
            if (up_down) begin
                w_count_nxt = r_count + ONE;
            end else begin
                w_count_nxt = r_count - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign data_out = r_count;

endmodule

// File: tb/tb_load_updown_counter.sv
// Directed, table-driven bench for load_updown_counter (WIDTH = 8).
module tb_load_updown_counter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] data_out;

    int n_checks;
    int n_fail;

    typedef struct {
        string            name;
        logic             load;
        logic             enable;
        logic             up_down;
        logic [WIDTH-1:0] data_in;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    load_updown_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .enable   (enable),
        .up_down  (up_down),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic ld, input logic en,
                                input logic ud, input logic [WIDTH-1:0] din,
                                input logic [WIDTH-1:0] exp);
        vec_t v;
        v.name = name; v.load = ld; v.enable = en; v.up_down = ud;
        v.data_in = din; v.exp = exp;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Expected values after each edge, hand-computed from the previous row.
        vecs.push_back(mk("load10",    1, 0, 0, 8'd10,  8'd10));
        vecs.push_back(mk("hold0",     0, 0, 1, 8'd77,  8'd10));
        vecs.push_back(mk("hold1",     0, 0, 0, 8'd3,   8'd10));
        vecs.push_back(mk("hold2",     0, 0, 1, 8'd200, 8'd10));
        vecs.push_back(mk("hold3",     0, 0, 0, 8'd0,   8'd10));
        vecs.push_back(mk("hold4",     0, 0, 1, 8'd255, 8'd10));
        vecs.push_back(mk("up11",      0, 1, 1, 8'd0,   8'd11));
        vecs.push_back(mk("up12",      0, 1, 1, 8'd99,  8'd12));
        vecs.push_back(mk("up13",      0, 1, 1, 8'd0,   8'd13));
        vecs.push_back(mk("up14",      0, 1, 1, 8'd1,   8'd14));
        vecs.push_back(mk("up15",      0, 1, 1, 8'd0,   8'd15));
        vecs.push_back(mk("down14",    0, 1, 0, 8'd0,   8'd14));
        vecs.push_back(mk("down13",    0, 1, 0, 8'd50,  8'd13));
        vecs.push_back(mk("down12",    0, 1, 0, 8'd0,   8'd12));
        vecs.push_back(mk("load255",   1, 0, 1, 8'd255, 8'd255));
        vecs.push_back(mk("wrap_up",   0, 1, 1, 8'd0,   8'd0));
        vecs.push_back(mk("load0",     1, 1, 0, 8'd0,   8'd0));
        vecs.push_back(mk("wrap_down", 0, 1, 0, 8'd0,   8'd255));
        vecs.push_back(mk("ld_en_up",  1, 1, 1, 8'd100, 8'd100));
        vecs.push_back(mk("after_ld",  0, 1, 1, 8'd0,   8'd101));
        vecs.push_back(mk("ld_en_dn",  1, 1, 0, 8'd7,   8'd7));
        vecs.push_back(mk("dir_chg",   0, 1, 1, 8'd0,   8'd8));

        // Reset with random controls: clears immediately and holds for 2 cycles.
        load    = 1'($urandom);
        enable  = 1'($urandom);
        up_down = 1'($urandom);
        data_in = WIDTH'($urandom);
        reset   = 1'b1;
        #1;
        check("reset_async", data_out, 8'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load    = 1'($urandom);
            enable  = 1'($urandom);
            up_down = 1'($urandom);
            data_in = WIDTH'($urandom);
            @(negedge clk);
            check("reset_hold", data_out, 8'd0);
        end
        reset = 1'b0;

        // Table vectors: drive on negedge, sample on the following negedge.
        foreach (vecs[i]) begin
            load    = vecs[i].load;
            enable  = vecs[i].enable;
            up_down = vecs[i].up_down;
            data_in = vecs[i].data_in;
            @(negedge clk);
            check(vecs[i].name, data_out, vecs[i].exp);
        end

        // Reset in the same cycle as a load: load is discarded.
        load = 1'b1; enable = 1'b1; up_down = 1'b1; data_in = 8'd55;
        reset = 1'b1;
        #1;
        check("rst_vs_load_async", data_out, 8'd0);
        @(negedge clk);
        check("rst_vs_load_edge", data_out, 8'd0);
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("rst_vs_load_after", data_out, 8'd0);

        // Reset mid-count between edges, then resume counting from 0.
        load = 1'b1; data_in = 8'd10; enable = 1'b0;
        @(negedge clk);
        check("mid_load10", data_out, 8'd10);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_up13", data_out, 8'd13);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_async", data_out, 8'd0);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("resume_up", data_out, WIDTH'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
